// File: rtl/spi_burst_ram_pkg.sv
// spi_burst_ram shared types: command encoding and address range helper.
// Optional parity storage is enabled with SPI_RAM_PARITY_EN.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    SET_WR_ADDR = 2'b00,
    WRITE       = 2'b01,
    SET_RD_ADDR = 2'b10,
    READ        = 2'b11
  } cmd_e;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Payload is accepted as an address only if it names an existing word;
  // any nonzero bit above the address field already exceeds the depth.
  function automatic logic addr_in_range(input logic [63:0] val,
                                         input int unsigned depth);
    return val < 64'(depth);
  endfunction

endpackage

// File: rtl/spi_burst_ram_if.sv
// Parallel command/response bus between the SPI front end and the RAM.
// SPI_RAM_PARITY_EN adds the force_parity_flip hook to the bus.
interface spi_burst_ram_if
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH  = 256,
  parameter int DATA_WIDTH = 8
);
  localparam int ADDR_SIZE = $clog2(MEM_DEPTH);
  localparam int PAYLOAD_W = max_i(ADDR_SIZE, DATA_WIDTH);

  logic                   rx_valid;
  logic [PAYLOAD_W+1:0]   rx_data;
  logic [DATA_WIDTH-1:0]  tx_data;
  logic                   tx_valid;
  logic                   addr_err;
  logic                   tx_perr;
`ifdef SPI_RAM_PARITY_EN
  logic                   force_parity_flip;
`endif

  modport master (
    output rx_valid, rx_data,
`ifdef SPI_RAM_PARITY_EN
    output force_parity_flip,
`endif
    input  tx_data, tx_valid, addr_err, tx_perr
  );

  modport slave (
    input  rx_valid, rx_data,
`ifdef SPI_RAM_PARITY_EN
    input  force_parity_flip,
`endif
    output tx_data, tx_valid, addr_err, tx_perr
  );

endinterface

// File: rtl/spi_burst_ram_ptr.sv
// Loadable address counter that wraps from MEM_DEPTH-1 to 0,
// also for depths that are not a power of two.
module spi_ram_ptr #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ADDR_SIZE-1:0] load_val,
  input  logic                 inc,
  output logic [ADDR_SIZE-1:0] value
);
  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_DEPTH - 1);

  logic [ADDR_SIZE-1:0] value_d, value_q;

  // Load has priority; increment wraps at the last word.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (inc) begin
      value_d = (value_q == LAST) ? '0 : value_q + ADDR_SIZE'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/spi_burst_ram.sv
// Single-port burst RAM behind the SPI serial-to-parallel front end.
// Define SPI_RAM_PARITY_EN to store and check an even-parity bit per word.
module spi_burst_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH  = 256,
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  spi_burst_ram_if.slave bus
);
  localparam int ADDR_SIZE = $clog2(MEM_DEPTH);
  localparam int PAYLOAD_W = max_i(ADDR_SIZE, DATA_WIDTH);
`ifdef SPI_RAM_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif

  cmd_e                  cmd;
  logic [PAYLOAD_W-1:0]  payload;
  logic                  addr_ok;
  logic                  wr_load, wr_inc;
  logic                  rd_load, rd_inc;
  logic [ADDR_SIZE-1:0]  wr_ptr, rd_ptr;
  logic [MEM_W-1:0]      mem [MEM_DEPTH];
  logic [MEM_W-1:0]      wr_word, rd_word;

  logic [DATA_WIDTH-1:0] tx_data_d, tx_data_q;
  logic                  tx_valid_d, tx_valid_q;
  logic                  addr_err_d, addr_err_q;

  // Command decode into pointer controls and next output values.
  always_comb begin
    cmd        = cmd_e'(bus.rx_data[PAYLOAD_W+1:PAYLOAD_W]);
    payload    = bus.rx_data[PAYLOAD_W-1:0];
    addr_ok    = addr_in_range(64'(payload), MEM_DEPTH);
    wr_load    = 1'b0;
    wr_inc     = 1'b0;
    rd_load    = 1'b0;
    rd_inc     = 1'b0;
    addr_err_d = 1'b0;
    if (bus.rx_valid) begin
      unique case (cmd)
        SET_WR_ADDR: begin
          wr_load    = addr_ok;
          addr_err_d = ~addr_ok;
        end
        WRITE:       wr_inc = 1'b1;
        SET_RD_ADDR: begin
          rd_load    = addr_ok;
          addr_err_d = ~addr_ok;
        end
        READ:        rd_inc = 1'b1;
      endcase
    end
    rd_word    = mem[rd_ptr];
    tx_valid_d = rd_inc;
    tx_data_d  = rd_inc ? rd_word[DATA_WIDTH-1:0] : tx_data_q;
  end

  spi_ram_ptr #(.ADDR_SIZE(ADDR_SIZE), .MEM_DEPTH(MEM_DEPTH)) u_wr_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (wr_load),
    .load_val (payload[ADDR_SIZE-1:0]),
    .inc      (wr_inc),
    .value    (wr_ptr)
  );

  spi_ram_ptr #(.ADDR_SIZE(ADDR_SIZE), .MEM_DEPTH(MEM_DEPTH)) u_rd_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (rd_load),
    .load_val (payload[ADDR_SIZE-1:0]),
    .inc      (rd_inc),
    .value    (rd_ptr)
  );

`ifdef SPI_RAM_PARITY_EN
  logic flip_now;
  logic flip_pend_d, flip_pend_q;
  logic tx_perr_d, tx_perr_q;

  // A requested flip is held until the next WRITE consumes it.
  always_comb begin
    flip_now    = flip_pend_q | bus.force_parity_flip;
    flip_pend_d = flip_now & ~wr_inc;
    wr_word     = {(^payload[DATA_WIDTH-1:0]) ^ flip_now,
                   payload[DATA_WIDTH-1:0]};
    tx_perr_d   = rd_inc &
                  ((^rd_word[DATA_WIDTH-1:0]) != rd_word[DATA_WIDTH]);
  end

  // Parity status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flip_pend_q <= 1'b0;
      tx_perr_q   <= 1'b0;
    end else begin
      flip_pend_q <= flip_pend_d;
      tx_perr_q   <= tx_perr_d;
    end
  end

  assign bus.tx_perr = tx_perr_q;
`else
  // Stored word is the payload data field only.
  always_comb begin
    wr_word = payload[DATA_WIDTH-1:0];
  end

  assign bus.tx_perr = 1'b0;
`endif

  // Storage: written on WRITE, never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_inc) mem[wr_ptr] <= wr_word;
  end

  // Registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_burst_ram.sv
// Randomized self-checking bench for spi_burst_ram (depth 200, 8-bit words).
// Parity checks are active when SPI_RAM_PARITY_EN is defined.
module tb_spi_burst_ram;
  localparam int DEPTH = 200;
  localparam int DW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_burst_ram_if #(.MEM_DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

  spi_burst_ram #(.MEM_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem_m  [DEPTH];
  bit            known  [DEPTH];
  bit            perr_m [DEPTH];
  int            wr_m, rd_m;
  logic [DW-1:0] tx_m;
  bit            tx_known;
  bit            flip_m;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    wr_m     = 0;
    rd_m     = 0;
    tx_m     = '0;
    tx_known = 1'b1;
    flip_m   = 1'b0;
  endtask

  // One bus cycle: drive, predict from the model, then check after the edge.
  task automatic step(input bit v, input logic [1:0] c,
                      input logic [DW-1:0] p);
    bit ev, ea, ep;
    ev = 0; ea = 0; ep = 0;
    @(negedge clk);
    bus.rx_valid = v;
    bus.rx_data  = {c, p};
    if (v) begin
      case (c)
        2'd0: if (int'(p) < DEPTH) wr_m = int'(p); else ea = 1;
        2'd1: begin
          mem_m[wr_m]  = p;
          known[wr_m]  = 1;
          perr_m[wr_m] = flip_m;
          flip_m       = 0;
          wr_m         = (wr_m + 1) % DEPTH;
        end
        2'd2: if (int'(p) < DEPTH) rd_m = int'(p); else ea = 1;
        default: begin
          ev       = 1;
          tx_m     = mem_m[rd_m];
          tx_known = known[rd_m];
          ep       = perr_m[rd_m];
          rd_m     = (rd_m + 1) % DEPTH;
        end
      endcase
    end
    @(posedge clk);
    #1;
    chk("tx_valid", 32'(bus.tx_valid), 32'(ev));
    chk("addr_err", 32'(bus.addr_err), 32'(ea));
    if (tx_known) chk("tx_data", 32'(bus.tx_data), 32'(tx_m));
`ifdef SPI_RAM_PARITY_EN
    chk("tx_perr", 32'(bus.tx_perr), 32'(ep));
`else
    chk("tx_perr", 32'(bus.tx_perr), 32'(0));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    #1;
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'(0));
    chk("rst_tx_data", 32'(bus.tx_data), 32'(0));
    chk("rst_addr_err", 32'(bus.addr_err), 32'(0));
    chk("rst_tx_perr", 32'(bus.tx_perr), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
`ifdef SPI_RAM_PARITY_EN
    bus.force_parity_flip = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      known[i]  = 0;
      perr_m[i] = 0;
      mem_m[i]  = '0;
    end
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();

    // Burst write then burst read.
    step(1, 2'd0, 8'd5);
    step(1, 2'd1, 8'hA1);
    step(1, 2'd1, 8'hB2);
    step(1, 2'd1, 8'hC3);
    step(1, 2'd2, 8'd5);
    step(1, 2'd3, 8'h00);
    step(1, 2'd3, 8'h00);
    step(1, 2'd3, 8'h00);
    step(0, 2'd3, 8'h00);

    // Fill the whole memory with random data.
    step(1, 2'd0, 8'd0);
    for (int i = 0; i < DEPTH; i++) step(1, 2'd1, 8'($urandom));

    // Wrap at the last word.
    step(1, 2'd0, 8'd199);
    step(1, 2'd1, 8'h11);
    step(1, 2'd1, 8'h22);
    step(1, 2'd2, 8'd199);
    step(1, 2'd3, 8'h00);
    step(1, 2'd3, 8'h00);

    // Out-of-range address leaves the pointer alone.
    step(1, 2'd2, 8'd17);
    step(1, 2'd2, 8'd210);
    step(1, 2'd3, 8'h00);
    step(1, 2'd0, 8'd255);
    step(1, 2'd1, 8'h77);

    // Read immediately after write.
    step(1, 2'd0, 8'd3);
    step(1, 2'd2, 8'd3);
    step(1, 2'd1, 8'h5A);
    step(1, 2'd3, 8'h00);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 9) < 8), 2'($urandom), 8'($urandom));
    end

    // Reset in the middle of a read burst.
    step(1, 2'd2, 8'd40);
    step(1, 2'd3, 8'h00);
    step(1, 2'd3, 8'h00);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = {2'd3, 8'h00};
    rst = 1'b1;
    #1;
    chk("midrst_tx_valid", 32'(bus.tx_valid), 32'(0));
    chk("midrst_tx_data", 32'(bus.tx_data), 32'(0));
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) step(1, 2'd3, 8'h00);
    step(1, 2'd2, 8'd120);
    step(1, 2'd3, 8'h00);
    step(1, 2'd3, 8'h00);

`ifdef SPI_RAM_PARITY_EN
    // Corrupted parity on one word, clean parity on the next.
    @(negedge clk);
    bus.rx_valid          = 1'b0;
    bus.force_parity_flip = 1'b1;
    @(negedge clk);
    bus.force_parity_flip = 1'b0;
    flip_m = 1'b1;
    step(1, 2'd0, 8'd60);
    step(1, 2'd1, 8'h0F);
    step(1, 2'd1, 8'h3C);
    step(1, 2'd2, 8'd60);
    step(1, 2'd3, 8'h00);
    step(1, 2'd3, 8'h00);
`endif

    step(0, 2'd0, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_burst_ram.md
Name: spi_burst_ram

Overview:
Parametrised single-port RAM slave behind the SPI wrapper's serial-to-parallel front end. Decodes 2-bit command plus payload words from the SPI slave and returns read data. Generalises the fixed 8-bit-data, 256-deep RAM: width and depth are independent, and write and read address pointers auto-increment for burst transfers. Reports out-of-range addresses.

Parameters:
MEM_DEPTH, 256, number of words; any value >= 2, not necessarily a power of two
DATA_WIDTH, 8, word width in bits
ADDR_SIZE, $clog2(MEM_DEPTH), localparam, address width
PAYLOAD_W, max(ADDR_SIZE, DATA_WIDTH), localparam, payload field width of rx_data

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
rx_valid  input  1  rx_data holds one command this cycle
rx_data  input  PAYLOAD_W+2  [PAYLOAD_W+1:PAYLOAD_W] = cmd, [PAYLOAD_W-1:0] = payload
tx_data  output  DATA_WIDTH  read data
tx_valid  output  1  one-cycle strobe qualifying tx_data
addr_err  output  1  one-cycle strobe: address command rejected
tx_perr  output  1  parity error qualifying tx_data (see Optional Feature)

Behaviour:
- Reset values while rst is high: tx_data=0, tx_valid=0, addr_err=0, tx_perr=0, wr_ptr=0, rd_ptr=0. Memory contents are not cleared.
- One command per cycle with rx_valid=1. Commands are ignored when rx_valid=0.
- cmd 00, SET_WR_ADDR: wr_ptr <= payload[ADDR_SIZE-1:0].
- cmd 01, WRITE: mem[wr_ptr] <= payload[DATA_WIDTH-1:0]. Then wr_ptr increments.
- cmd 10, SET_RD_ADDR: rd_ptr <= payload[ADDR_SIZE-1:0]. Produces no tx output.
- cmd 11, READ: tx_data <= mem[rd_ptr] and tx_valid=1 on the next edge (latency 1). Then rd_ptr increments.
- tx_valid is high for exactly one cycle per READ. Back-to-back READs give back-to-back strobes.
- With no READ, tx_data holds its last value.
- Pointer increment wraps explicitly: MEM_DEPTH-1 -> 0. This applies for non-power-of-2 depths too.
- Address range check on cmd 00/10: if payload bits above ADDR_SIZE are nonzero, or the value is >= MEM_DEPTH:
  - the pointer is unchanged;
  - addr_err pulses for 1 cycle on the next edge.
- Payload bits above DATA_WIDTH on WRITE are ignored.
- Read-after-write: WRITE at cycle N, then READ of the same address at N+1 returns the new word.
- READ before any SET_RD_ADDR reads address 0.
- Reset mid-burst: pointers return to 0 and any pending tx_valid is dropped. Stored words persist.
- No internal FSM beyond the pointers. All outputs are registered.

Optional Feature:
Macro SPI_RAM_PARITY_EN.
- Defined:
  - each word stores one extra even-parity bit, computed on WRITE;
  - on READ, tx_perr = recomputed parity != stored bit, aligned with tx_valid;
  - the bench hook force_parity_flip inverts the stored bit of the next WRITE.
- Undefined:
  - no parity storage;
  - tx_perr is tied 0;
  - the port list is unchanged.

Decomposition:
- Package spi_ram_pkg:
  - typedef enum logic [1:0] cmd_e {SET_WR_ADDR=2'b00, WRITE=2'b01, SET_RD_ADDR=2'b10, READ=2'b11};
  - helper function for the range check.
- Sub-module spi_ram_ptr (ADDR_SIZE, MEM_DEPTH): loadable wrapping counter with load, inc, value. Instantiated twice, for wr_ptr and rd_ptr.
- Storage is an inferred array in the top level.

Test Plan:
1. Reset then SET_WR_ADDR 5, WRITE 0xA1, 0xB2, 0xC3, SET_RD_ADDR 5, READ x3 -> tx_data 0xA1, 0xB2, 0xC3 on three consecutive cycles, each with tx_valid=1, one cycle after its READ.
2. MEM_DEPTH=200: SET_WR_ADDR 199, WRITE 0x11, WRITE 0x22, SET_RD_ADDR 199, READ x2 -> 0x11 then 0x22; the second comes from address 0 (wrap).
3. MEM_DEPTH=200: SET_RD_ADDR 210 -> addr_err pulses 1 cycle, rd_ptr unchanged. A following READ returns the previous pointer's word with addr_err=0.
4. WRITE 0x5A to address 3 at cycle N, READ of address 3 at N+1 -> tx_data=0x5A at N+2.
5. Assert rst during a 4-word READ burst after the 2nd word -> tx_valid drops immediately. After release, READ returns mem[0], and previously written data is intact.
6. With SPI_RAM_PARITY_EN: force_parity_flip then WRITE 0x0F, read it back -> tx_perr=1 with tx_valid. A normal word reads back with tx_perr=0. Without the macro, tx_perr is always 0.
